jesd204b_tx_link_ctrl: RTL and testbench
========================================

JESD204B_TX_LINK_CTRL -- requirements
Module: jesd204b_tx_link_ctrl

Interface
REQ-001 The block SHALL have parameter F, default 2, octets per frame (1..256).
REQ-002 The block SHALL have parameter K, default 32, frames per multiframe (1..32); F*K SHALL be 17..1024.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port sync_n, input, 1, receiver SYNC~ (asynchronous, active low).
REQ-006 The block SHALL have port ilas_cfg, input, 112, ILAS config octets 0..13; octet n = bits [8n+7:8n].
REQ-007 The block SHALL have port tx_data, input, 8, user octet.
REQ-008 The block SHALL have port tx_valid, input, 1, tx_data valid.
REQ-009 The block SHALL have port tx_ready, output, 1, octet accepted when tx_valid & tx_ready.
REQ-010 The block SHALL have port tx_char, output, 8, octet to 8b/10b encoder (HGFEDCBA).
REQ-011 The block SHALL have port tx_is_k, output, 1, tx_char is a control character.
REQ-012 The block SHALL have port lmfc_start, output, 1, tx_char is octet 0 of a multiframe.
REQ-013 The block SHALL have port link_state, output, 2, 0=CGS, 1=ILAS, 2=DATA.
REQ-014 The block SHALL have port underflow, output, 1, one-cycle pulse on DATA-phase starvation.

Function
REQ-015 sync_n SHALL pass a 2-flop synchronizer (sync_s); sync_s lags sync_n by 2 clocks.
REQ-016 A free-running LMFC counter, width clog2(F*K), SHALL count 0..F*K-1 and wrap to 0, one octet per clock, in every state.
REQ-017 All outputs SHALL be registered; tx_char/tx_is_k/lmfc_start SHALL describe the octet at the position the LMFC counter held in the previous cycle, so lmfc_start=1 coincides with position 0 on tx_char.
REQ-018 CGS: tx_char=0xBC (K28.5), tx_is_k=1, tx_ready=0.
REQ-019 CGS->ILAS SHALL occur when sync_s=1 and the next emitted octet is position 0; the first ILAS octet coincides with lmfc_start=1.
REQ-020 ILAS SHALL span exactly 4 multiframes (4*F*K octets), per multiframe: position 0 = 0x1C K28.0 (k=1); position F*K-1 = 0x7C K28.3 (k=1).
REQ-021 ILAS multiframe 1 (second): position 1 = 0x9C K28.4 (k=1); positions 2..15 = ilas_cfg octets 0..13 (k=0).
REQ-022 All other ILAS positions SHALL be fill data tx_char = position[7:0], k=0.
REQ-023 ilas_cfg SHALL be sampled at each emitted config octet; it is required stable throughout ILAS.
REQ-024 After the fourth K28.3, DATA SHALL begin at the next octet (position 0).
REQ-025 DATA: tx_ready=1 in every cycle whose decision produces a DATA octet; the accepted tx_data SHALL appear on tx_char one cycle later, k=0.
REQ-026 DATA with tx_valid=0: tx_char=0x00, k=0, underflow=1 for that octet's cycle.
REQ-027 In ILAS or DATA, sync_s=0 for 4 consecutive clocks SHALL force CGS; first K28.5 appears on the following output cycle; a partial multiframe is abandoned.
REQ-028 sync_s low fewer than 4 consecutive clocks SHALL be ignored; the counter clears when sync_s=1.
REQ-029 In CGS, sync_s returning high mid-multiframe SHALL keep K28.5 until the next position 0.
REQ-030 Resync (REQ-027) SHALL take priority over ILAS->DATA on the same cycle.
REQ-031 tx_ready SHALL be 0 in CGS and ILAS; tx_data is ignored there.

Reset
REQ-032 rst_n=0 SHALL immediately set state=CGS, LMFC counter=0, synchronizer flops=0 (SYNC asserted), tx_char=0xBC, tx_is_k=1, tx_ready=0, lmfc_start=0, underflow=0, link_state=0.
REQ-033 Reset deasserted mid-ILAS/DATA SHALL restart from CGS with LMFC position 0 on the first post-reset clock.

Verification (F=2, K=32, F*K=64)
REQ-034 Reset, sync_n=0 for 200 clocks -> tx_char=0xBC, k=1 continuously, link_state=0, lmfc_start every 64 cycles.
REQ-035 sync_n rises at LMFC position 10 -> K28.5 until next lmfc_start; then 0x1C k=1; 256 ILAS octets; 0x9C at octet 65; ilas_cfg octets 66..79; 0x7C at octets 63,127,191,255; link_state=2 from octet 256.
REQ-036 DATA, tx_valid=1 with ramp 0x00..0xFF -> tx_char repeats ramp one cycle after acceptance, k=0, underflow=0.
REQ-037 DATA, tx_valid=0 for 3 cycles -> tx_char=0x00 for 3 octets, underflow pulsed 3 times.
REQ-038 DATA, sync_n low 3 clocks -> no change; low 4+ clocks -> 0xBC k=1 within 2+4+1 clocks of fall, link_state=0, re-ILAS on next position 0 after sync_n high.
REQ-039 rst_n pulsed low during ILAS multiframe 2 -> outputs reset values asynchronously; sequence restarts in CGS.

Source files
------------

// File: rtl/jesd204b_tx_link_ctrl.sv
// -----------------------------------------------------------------------------
// jesd204b_tx_link_ctrl
// JESD204B transmit link-layer controller. Generates code-group sync (K28.5),
// the four-multiframe initial lane alignment sequence, then user data, all
// aligned to a free-running local multiframe clock (LMFC) position counter.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   sync_n     : receiver SYNC~ (asynchronous, active low)
//   ilas_cfg   : ILAS configuration octets 0..13, octet n = bits [8n+7:8n]
//   tx_data    : user octet
//   tx_valid   : tx_data valid
//   tx_ready   : octet accepted when tx_valid & tx_ready
//   tx_char    : octet to the 8b/10b encoder (HGFEDCBA)
//   tx_is_k    : tx_char is a control character
//   lmfc_start : tx_char is octet 0 of a multiframe
//   link_state : 0 = CGS, 1 = ILAS, 2 = DATA (phase of the octet on tx_char)
//   underflow  : one-cycle pulse when a DATA octet had no valid user data
// -----------------------------------------------------------------------------
module jesd204b_tx_link_ctrl #(
    parameter int F = 2,
    parameter int K = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sync_n,
    input  logic [111:0] ilas_cfg,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [7:0]   tx_char,
    output logic         tx_is_k,
    output logic         lmfc_start,
    output logic [1:0]   link_state,
    output logic         underflow
);

    localparam int FK = F * K;
    localparam int LW = $clog2(FK);
    localparam logic [LW-1:0] LAST_POS = LW'(FK - 1);
    localparam logic [15:0]   LAST_POS16 = 16'(FK - 1);

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // ILAS octet for a multiframe position: returns {is_k, char}.
    function automatic logic [8:0] ilas_octet(input logic [15:0]  pos,
                                              input logic [1:0]   mf,
                                              input logic [111:0] cfg);
        logic [8:0] o;
        logic [3:0] cidx;
        cidx = pos[3:0] - 4'd2;
        if (pos == 16'd0) begin
            o = {1'b1, 8'h1C};
        end else if (pos == LAST_POS16) begin
            o = {1'b1, 8'h7C};
        end else if ((mf == 2'd1) && (pos == 16'd1)) begin
            o = {1'b1, 8'h9C};
        end else if ((mf == 2'd1) && (pos >= 16'd2) && (pos <= 16'd15)) begin
            o = {1'b0, cfg[{cidx, 3'b000} +: 8]};
        end else begin
            o = {1'b0, pos[7:0]};
        end
        return o;
    endfunction

    state_e        state_q, state_d;
    logic          sync_meta_q, sync_q;
    logic [LW-1:0] lmfc_q, lmfc_d;
    logic [1:0]    mf_q, mf_d;
    logic [1:0]    low_cnt_q, low_cnt_d;
    logic [7:0]    tx_char_q, tx_char_d;
    logic          tx_is_k_q, tx_is_k_d;
    logic          lmfc_start_q, lmfc_start_d;
    logic          tx_ready_q, tx_ready_d;
    logic          underflow_q, underflow_d;
    logic [1:0]    link_state_q, link_state_d;
    logic          resync_s, nxt_resync_s;
    logic [15:0]   pos_s;
    logic [8:0]    ilas_oct_s;

    // Next-state decision: picks the octet for LMFC position lmfc_q.
    always_comb begin
        state_d      = state_q;
        mf_d         = mf_q;
        tx_char_d    = 8'hBC;
        tx_is_k_d    = 1'b1;
        underflow_d  = 1'b0;
        link_state_d = ST_CGS;
        lmfc_start_d = (lmfc_q == '0);
        pos_s        = {{(16 - LW){1'b0}}, lmfc_q};

        if (lmfc_q == LAST_POS) begin
            lmfc_d = '0;
        end else begin
            lmfc_d = lmfc_q + LW'(1);
        end

        // Consecutive-low counter on synchronized SYNC~, saturating at 3.
        if (sync_q) begin
            low_cnt_d = 2'd0;
        end else if (low_cnt_q == 2'd3) begin
            low_cnt_d = 2'd3;
        end else begin
            low_cnt_d = low_cnt_q + 2'd1;
        end

        // Fourth consecutive low sample forces CGS; beats ILAS->DATA.
        resync_s   = (state_q != ST_CGS) && !sync_q && (low_cnt_q == 2'd3);
        ilas_oct_s = ilas_octet(pos_s, (state_q == ST_ILAS) ? mf_q : 2'd0, ilas_cfg);

        case (state_q)
            ST_CGS: begin
                if (sync_q && (lmfc_q == '0)) begin
                    state_d      = ST_ILAS;
                    mf_d         = 2'd0;
                    {tx_is_k_d, tx_char_d} = ilas_oct_s;
                    link_state_d = ST_ILAS;
                end else begin
                    state_d = ST_CGS;
                end
            end
            ST_ILAS: begin
                if (resync_s) begin
                    state_d = ST_CGS;
                    mf_d    = 2'd0;
                end else begin
                    {tx_is_k_d, tx_char_d} = ilas_oct_s;
                    link_state_d = ST_ILAS;
                    if (lmfc_q == LAST_POS) begin
                        mf_d = mf_q + 2'd1;
                        if (mf_q == 2'd3) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_ILAS;
                        end
                    end else begin
                        mf_d = mf_q;
                    end
                end
            end
            ST_DATA: begin
                if (resync_s) begin
                    state_d = ST_CGS;
                    mf_d    = 2'd0;
                end else begin
                    link_state_d = ST_DATA;
                    tx_is_k_d    = 1'b0;
                    if (tx_valid) begin
                        tx_char_d = tx_data;
                    end else begin
                        tx_char_d   = 8'h00;
                        underflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CGS;
                mf_d    = 2'd0;
            end
        endcase

        // tx_ready is registered, so it predicts whether the next decision
        // will produce a DATA octet using the next-cycle view of the
        // synchronizer and low counter.
        nxt_resync_s = (state_d != ST_CGS) && !sync_meta_q && (low_cnt_d == 2'd3);
        tx_ready_d   = (state_d == ST_DATA) && !nxt_resync_s;
    end

    // State, LMFC counter, SYNC~ synchronizer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CGS;
            sync_meta_q  <= 1'b0;
            sync_q       <= 1'b0;
            lmfc_q       <= '0;
            mf_q         <= 2'd0;
            low_cnt_q    <= 2'd0;
            tx_char_q    <= 8'hBC;
            tx_is_k_q    <= 1'b1;
            lmfc_start_q <= 1'b0;
            tx_ready_q   <= 1'b0;
            underflow_q  <= 1'b0;
            link_state_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            sync_meta_q  <= sync_n;
            sync_q       <= sync_meta_q;
            lmfc_q       <= lmfc_d;
            mf_q         <= mf_d;
            low_cnt_q    <= low_cnt_d;
            tx_char_q    <= tx_char_d;
            tx_is_k_q    <= tx_is_k_d;
            lmfc_start_q <= lmfc_start_d;
            tx_ready_q   <= tx_ready_d;
            underflow_q  <= underflow_d;
            link_state_q <= link_state_d;
        end
    end

    assign tx_char    = tx_char_q;
    assign tx_is_k    = tx_is_k_q;
    assign lmfc_start = lmfc_start_q;
    assign tx_ready   = tx_ready_q;
    assign underflow  = underflow_q;
    assign link_state = link_state_q;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jesd204b_tx_link_ctrl
// Directed bench for jesd204b_tx_link_ctrl with F=2, K=32 (64 octets per
// multiframe): reset, CGS, ILAS content, DATA ramp, underflow, SYNC~ glitch
// filtering, resync, and asynchronous reset during ILAS.
// -----------------------------------------------------------------------------
module tb_jesd204b_tx_link_ctrl;

    logic         clk;
    logic         rst_n;
    logic         sync_n;
    logic [111:0] ilas_cfg;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   tx_char;
    logic         tx_is_k;
    logic         lmfc_start;
    logic [1:0]   link_state;
    logic         underflow;

    int total;
    int bad;
    int cyc;
    int seen;

    jesd204b_tx_link_ctrl #(.F(2), .K(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_n     (sync_n),
        .ilas_cfg   (ilas_cfg),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_char    (tx_char),
        .tx_is_k    (tx_is_k),
        .lmfc_start (lmfc_start),
        .link_state (link_state),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Octet on tx_char after edge number cyc belongs to LMFC position (cyc-1)%64.
    task automatic chk_oct(input string tag, input logic [7:0] ch, input logic k,
                           input logic [1:0] ls, input logic rdy, input logic uf);
        chk({tag, "_char"}, {24'd0, tx_char}, {24'd0, ch});
        chk({tag, "_k"}, {31'd0, tx_is_k}, {31'd0, k});
        chk({tag, "_state"}, {30'd0, link_state}, {30'd0, ls});
        chk({tag, "_ready"}, {31'd0, tx_ready}, {31'd0, rdy});
        chk({tag, "_uflow"}, {31'd0, underflow}, {31'd0, uf});
        chk({tag, "_lmfc"}, {31'd0, lmfc_start}, (((cyc - 1) % 64) == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_char"}, {24'd0, tx_char}, 32'h0000_00BC);
        chk({tag, "_k"}, {31'd0, tx_is_k}, 32'd1);
        chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd0);
        chk({tag, "_lmfc"}, {31'd0, lmfc_start}, 32'd0);
        chk({tag, "_uflow"}, {31'd0, underflow}, 32'd0);
        chk({tag, "_state"}, {30'd0, link_state}, 32'd0);
    endtask

    // Expected ILAS octet i (0..255) as {k, char}.
    function automatic logic [8:0] exp_ilas(input int i);
        int p;
        int mf;
        p  = i % 64;
        mf = i / 64;
        if (p == 0)                          return {1'b1, 8'h1C};
        else if (p == 63)                    return {1'b1, 8'h7C};
        else if (mf == 1 && p == 1)          return {1'b1, 8'h9C};
        else if (mf == 1 && p >= 2 && p <= 15) return {1'b0, 8'(8'hA0 + p - 2)};
        else                                 return {1'b0, 8'(p)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        seen     = 0;
        rst_n    = 1'b0;
        sync_n   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ilas_cfg = '0;
        for (int n = 0; n < 14; n++) ilas_cfg[8*n +: 8] = 8'(8'hA0 + n);

        #23;
        chk_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // CGS with SYNC~ held low
        for (int c = 0; c < 200; c++) begin
            step();
            chk_oct("cgs", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        while (((cyc - 1) % 64) != 10) begin
            step();
            chk_oct("cgs_pre", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        sync_n = 1'b1;
        while (((cyc - 1) % 64) != 63) begin
            step();
            chk_oct("cgs_hold", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end

        // ILAS: four multiframes
        for (int i = 0; i < 256; i++) begin
            step();
            e = exp_ilas(i);
            chk_oct("ilas", e[7:0], e[8], 2'd1, (i == 255), 1'b0);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h00;

        // DATA ramp
        for (int j = 0; j < 256; j++) begin
            step();
            chk_oct("data", 8'(j), 1'b0, 2'd2, 1'b1, 1'b0);
            if (j < 255) tx_data = 8'(j + 1);
            else         tx_valid = 1'b0;
        end

        // Starvation for three octets
        for (int u = 0; u < 3; u++) begin
            step();
            chk_oct("uflow", 8'h00, 1'b0, 2'd2, 1'b1, 1'b1);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        step();
        chk_oct("after_uflow", 8'h5A, 1'b0, 2'd2, 1'b1, 1'b0);

        // SYNC~ low for only 3 clocks: ignored
        tx_data = 8'h10;
        sync_n  = 1'b0;
        for (int s = 0; s < 12; s++) begin
            step();
            chk_oct("glitch", 8'(8'h10 + s), 1'b0, 2'd2, 1'b1, 1'b0);
            tx_data = 8'(8'h11 + s);
            if (s == 2) sync_n = 1'b1;
        end

        // SYNC~ low long: back to CGS within 7 clocks
        sync_n = 1'b0;
        seen   = 0;
        for (int w = 0; w < 7; w++) begin
            step();
            if (tx_char === 8'hBC && tx_is_k === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("resync_seen", seen, 32'd1);
        chk("resync_state", {30'd0, link_state}, 32'd0);
        chk("resync_ready", {31'd0, tx_ready}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk_oct("resync_cgs", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        while (((cyc - 1) % 64) != 20) begin
            step();
            chk_oct("resync_wait", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        sync_n = 1'b1;
        while (((cyc - 1) % 64) != 63) begin
            step();
            chk_oct("resync_hold", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end

        // Re-ILAS, then asynchronous reset in multiframe 2
        for (int i = 0; i <= 140; i++) begin
            step();
            e = exp_ilas(i);
            chk_oct("reilas", e[7:0], e[8], 2'd1, 1'b0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Restart from CGS; SYNC~ already high, ILAS on second position 0
        for (int c = 0; c < 64; c++) begin
            step();
            chk_oct("post_rst_cgs", 8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        step();
        chk_oct("post_rst_ilas", 8'h1C, 1'b1, 2'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
